mdu: RTL and testbench

Parametrised multi-cycle multiply/divide unit implementing the RISC-V M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle `alu` in the execute stage. The execute stage routes M-extension instructions here through a valid/ready handshake, stalls while the unit is busy, and writes back on `outValid`. The datapath iterates `UNROLL` bits per cycle and handles the divide-by-zero and signed-overflow corner cases in a one-cycle fast path.

---
 rtl/md_pkg.sv | 24 ++
 rtl/mdu_step.sv | 37 +++
 rtl/mdu.sv | 140 ++++++++++++++
 tb/tb_mdu.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: funct3 encodings,
// FSM state type and operand signedness helpers.
package md_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_DONE} md_state_t;

  function automatic logic md_is_signed_a(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_is_signed_b(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// Combinational UNROLL-deep iteration: shift-add multiply on {hi,lo}
// or restoring divide on {remainder,quotient}.
module mdu_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     sum;

  always_comb begin
    acc = acc_i;
    sum = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div_i) begin
        // remainder < divisor, so the shifted trial value fits XLEN+1 bits
        sum = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        if (sum >= {1'b0, opnd_i}) begin
          sum = sum - {1'b0, opnd_i};
          acc = {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
          acc = {sum[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
      end else begin
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + ({(XLEN+1){acc[0]}} & {1'b0, opnd_i});
        acc = {sum, acc[XLEN-1:1]};
      end
    end
    acc_o = acc;
  end

endmodule

// File: rtl/mdu.sv
// RISC-V M-extension multi-cycle multiply/divide unit: FSM, operand
// magnitudes, division fast path, sign fix-up and valid/ready handshake.
module mdu
  import md_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inValid,
  output logic            inReady,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      mdCtrl,
  input  logic            kill,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);

  md_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              na_q, na_d, nb_q, nb_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_nx, prod;
  logic [XLEN-1:0]   opnd_q, opnd_d, res_q, res_d;
  logic [XLEN-1:0]   a_mag, b_mag, quo, rem, fast_res, calc_res;
  logic              a_neg, b_neg, b_zero, ovf, fast, accept;

  mdu_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_nx)
  );

  always_comb begin
    a_neg    = md_is_signed_a(mdCtrl) & a[XLEN-1];
    b_neg    = md_is_signed_b(mdCtrl) & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    b_zero   = (b == '0);
    ovf      = ((mdCtrl == MD_DIV) || (mdCtrl == MD_REM)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    fast     = mdCtrl[2] && (b_zero || ovf);
    // mdCtrl[1] separates REM/REMU from DIV/DIVU
    if (b_zero) fast_res = mdCtrl[1] ? a : '1;
    else        fast_res = mdCtrl[1] ? '0 : a;

    prod = (na_q ^ nb_q) ? -acc_nx : acc_nx;
    quo  = (na_q ^ nb_q) ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem  = na_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                      calc_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: calc_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             calc_res = quo;
      default:                     calc_res = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    na_d    = na_q;
    nb_d    = nb_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    inReady = (state_q == MD_IDLE) && !kill;
    accept  = inValid && inReady;
    case (state_q)
      MD_IDLE: if (accept) begin
        op_d   = mdCtrl;
        na_d   = a_neg;
        nb_d   = b_neg;
        // multiplier / dividend sits in the low half, the other operand in opnd
        opnd_d = mdCtrl[2] ? b_mag : a_mag;
        acc_d  = {{XLEN{1'b0}}, (mdCtrl[2] ? a_mag : b_mag)};
        if (fast) begin
          state_d = MD_DONE;
          res_d   = fast_res;
        end else begin
          state_d = MD_CALC;
          cnt_d   = CW'(N);
        end
      end
      MD_CALC: begin
        acc_d = acc_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = MD_DONE;
          res_d   = calc_res;
        end
      end
      MD_DONE: if (outReady) begin
        state_d = MD_IDLE;
        res_d   = '0;
      end
      default: state_d = MD_IDLE;
    endcase
    if (kill) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MUL;
      na_q    <= 1'b0;
      nb_q    <= 1'b0;
      acc_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
    end
  end

  assign outValid = (state_q == MD_DONE);
  assign busy     = (state_q != MD_IDLE);
  assign result   = res_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: vector table for the eight operations and
// fast paths, plus stall, kill and reset sequences.
module tb_mdu;
  import md_pkg::*;

  localparam int XLEN = 32;
  localparam int NV   = 18;

  logic            clk = 1'b0, rst = 1'b1;
  logic            inValid = 1'b0, kill = 1'b0, outReady = 1'b1;
  logic [XLEN-1:0] a = '0, b = '0;
  logic [2:0]      mdCtrl = '0;
  logic            inReady, outValid, busy;
  logic [XLEN-1:0] result;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  mdu #(.XLEN(XLEN), .UNROLL(1)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .a(a), .b(b), .mdCtrl(mdCtrl), .kill(kill),
    .outValid(outValid), .outReady(outReady), .result(result), .busy(busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // call just after the accept edge; edges until outValid is seen (1 = next edge)
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!outValid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    mdCtrl = op; a = x; b = y; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  initial begin
    int lat;
    logic seen;
    vecs[0]  = '{MD_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{MD_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{MD_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[3]  = '{MD_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[4]  = '{MD_DIV,    32'hFFFFFFEC,   32'd3,        32'hFFFFFFFA, 33};
    vecs[5]  = '{MD_REM,    32'hFFFFFFEC,   32'd3,        32'hFFFFFFFE, 33};
    vecs[6]  = '{MD_DIVU,   32'd20,         32'd3,        32'd6,        33};
    vecs[7]  = '{MD_REMU,   32'd20,         32'd3,        32'd2,        33};
    vecs[8]  = '{MD_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{MD_REM,    32'd5,          32'd0,        32'd5,        1};
    vecs[10] = '{MD_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{MD_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{MD_MUL,    32'h12345678,   32'h00000010, 32'h23456780, 33};
    vecs[13] = '{MD_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[14] = '{MD_REM,    32'd7,          32'hFFFFFFFE, 32'd1,        33};
    vecs[15] = '{MD_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'd0,        33};
    vecs[16] = '{MD_DIV,    32'h80000000,   32'd1,        32'h80000000, 33};
    vecs[17] = '{MD_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset inReady", {31'd0, inReady}, 32'd1);
    chk("reset outValid", {31'd0, outValid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      mdCtrl = vecs[i].op; a = vecs[i].a; b = vecs[i].b; inValid = 1'b1;
      #1 chk($sformatf("v%0d inReady", i), {31'd0, inReady}, 32'd1);
      @(posedge clk); #1;
      inValid = 1'b0;
      wait_valid(lat);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d result", i), result, vecs[i].exp);
      @(posedge clk); #1;
      chk($sformatf("v%0d outValid after take", i), {31'd0, outValid}, 32'd0);
    end

    // consumer stall: DONE held with stable result
    outReady = 1'b0;
    send(MD_MUL, 32'd3, 32'd5);
    wait_valid(lat);
    chk("stall latency", lat, 33);
    repeat (10) begin
      @(negedge clk);
      chk("stall result", result, 32'd15);
      chk("stall outValid", {31'd0, outValid}, 32'd1);
      chk("stall inReady", {31'd0, inReady}, 32'd0);
    end
    outReady = 1'b1;
    mdCtrl = MD_DIVU; a = 32'd20; b = 32'd3; inValid = 1'b1;
    @(posedge clk); #1;
    chk("release outValid", {31'd0, outValid}, 32'd0);
    chk("release inReady", {31'd0, inReady}, 32'd1);
    chk("release result", result, 32'd0);
    @(posedge clk); #1;
    inValid = 1'b0;
    chk("new accept busy", {31'd0, busy}, 32'd1);
    wait_valid(lat);
    chk("new accept latency", lat, 33);
    chk("new accept result", result, 32'd6);
    @(posedge clk); #1;

    // kill in CALC cycle 5 together with a new request
    send(MD_MUL, 32'd9, 32'd9);
    repeat (4) @(posedge clk);
    @(negedge clk);
    kill = 1'b1; inValid = 1'b1; mdCtrl = MD_DIV; a = 32'd100; b = 32'd7;
    #1 chk("kill inReady", {31'd0, inReady}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0; inValid = 1'b0;
    chk("kill busy", {31'd0, busy}, 32'd0);
    chk("kill outValid", {31'd0, outValid}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (outValid || busy) seen = 1'b1;
    end
    chk("kill nothing accepted", {31'd0, seen}, 32'd0);

    // kill in IDLE blocks acceptance
    @(negedge clk);
    kill = 1'b1; inValid = 1'b1; mdCtrl = MD_DIVU; a = 32'd5; b = 32'd0;
    #1 chk("idle kill inReady", {31'd0, inReady}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0; inValid = 1'b0;
    chk("idle kill busy", {31'd0, busy}, 32'd0);

    // kill discards a held DONE result
    outReady = 1'b0;
    send(MD_REMU, 32'd5, 32'd0);
    wait_valid(lat);
    chk("done-kill latency", lat, 1);
    chk("done-kill held result", result, 32'd5);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("done-kill outValid", {31'd0, outValid}, 32'd0);
    chk("done-kill result", result, 32'd0);
    outReady = 1'b1;

    // reset mid-CALC
    send(MD_DIV, 32'd1000, 32'd7);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst inReady", {31'd0, inReady}, 32'd1);
    chk("rst outValid", {31'd0, outValid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst result", result, 32'd0);
    rst = 1'b0;
    send(MD_DIV, 32'd1000, 32'd7);
    wait_valid(lat);
    chk("post-rst latency", lat, 33);
    chk("post-rst result", result, 32'd142);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
